// File: rtl/instr_encoder.sv
// RV32I instruction word builder: two-stage valid/ready pipeline that range-checks
// the immediate, packs it into its format and tags each word with an imem address.
module instr_encoder #(
  parameter int              ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUIP = 7'b0010111;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_CSR  = 7'b1110011;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        s1_valid;
  logic [6:0]  s1_op;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [2:0]  s1_f3;
  logic [6:0]  s1_f7;
  logic [31:0] s1_imm;

  logic        s2_load, xfer;
  logic [31:0] enc_word, enc_instr;
  logic        enc_err;
  logic        imm12_ok, imm13_ok, imm21_ok;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign xfer     = out_valid && out_ready;

  // Signed range checks reduce to "all bits above the field's sign bit match it".
  assign imm12_ok = (s1_imm[31:11] == '0) || (s1_imm[31:11] == '1);
  assign imm13_ok = (s1_imm[31:12] == '0) || (s1_imm[31:12] == '1);
  assign imm21_ok = (s1_imm[31:20] == '0) || (s1_imm[31:20] == '1);

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (s1_op)
      OP_R: enc_word = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
      OP_IMM, OP_LOAD, OP_JALR: begin
        enc_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
        enc_err  = !imm12_ok;
      end
      OP_S: begin
        enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
        enc_err  = !imm12_ok;
      end
      OP_B: begin
        enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                    s1_imm[4:1], s1_imm[11], s1_op};
        enc_err  = s1_imm[0] || !imm13_ok;
      end
      OP_LUI, OP_AUIP: begin
        enc_word = {s1_imm[31:12], s1_rd, s1_op};
        enc_err  = (s1_imm[11:0] != '0);
      end
      OP_J: begin
        enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
        enc_err  = s1_imm[0] || !imm21_ok;
      end
      OP_CSR: begin
        enc_word = {s1_f7, s1_rs2, s1_imm[4:0], s1_f3, s1_rd, s1_op};
        enc_err  = (s1_imm[31:5] != '0);
      end
      default: enc_err = 1'b1;
    endcase
    enc_instr = enc_err ? NOP : enc_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_f3     <= '0;
      s1_f7     <= '0;
      s1_imm    <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      out_addr  <= BASE_ADDR;
      err_cnt   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op  <= opcode;
          s1_rd  <= rd;
          s1_rs1 <= rs1;
          s1_rs2 <= rs2;
          s1_f3  <= funct3;
          s1_f7  <= funct7;
          s1_imm <= imm;
        end
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_instr <= enc_instr;
          out_err   <= enc_err;
        end
      end
      // out_addr is the address counter itself; a word entering S2 in the same
      // cycle as a transfer picks up the incremented value.
      if (xfer) begin
        out_addr <= out_addr + ADDR_W'(4);
        if (out_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors, randomized fields against
// an arithmetic reference model, stall/hold behaviour, counter saturation and reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [6:0]  opcode = '0, funct7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] imm = '0;
  logic        out_valid, out_ready = 1'b0, out_err;
  logic [31:0] out_instr;
  logic [7:0]  out_addr, err_cnt;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; bit err; } exp_t;
  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   exp_addr = 0, exp_errcnt = 0;
  int   ready_mode = 0;          // 0: always ready, 1: random, 2: stalled
  bit   dir_use = 0;
  logic [31:0] dir_instr;
  bit   dir_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void ref_encode(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] im, output logic [31:0] w, output bit e);
    int v;
    v = $signed(im);
    w = '0;
    e = 0;
    case (op)
      7'b0110011: w = {f7, s2, s1, f3, d, op};
      7'b0010011, 7'b0000011, 7'b1100111: begin
        e = (v < -2048) || (v > 2047);
        w = {im[11:0], s1, f3, d, op};
      end
      7'b0100011: begin
        e = (v < -2048) || (v > 2047);
        w = {im[11:5], s2, s1, f3, im[4:0], op};
      end
      7'b1100011: begin
        e = (v % 2 != 0) || (v < -4096) || (v > 4094);
        w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
      end
      7'b0110111, 7'b0010111: begin
        e = (im % 4096) != 0;
        w = {im[31:12], d, op};
      end
      7'b1101111: begin
        e = (v % 2 != 0) || (v < -(1 << 20)) || (v > (1 << 20) - 2);
        w = {im[20], im[10:1], im[11], im[19:12], d, op};
      end
      7'b1110011: begin
        e = (v < 0) || (v > 31);
        w = {f7, s2, im[4:0], f3, d, op};
      end
      default: e = 1;
    endcase
    if (e) w = 32'h0000_0013;
  endfunction

  // Monitor: samples 2 time units after each falling edge, when inputs are settled.
  bit          hold_pend = 0;
  logic [31:0] hold_instr;
  logic [7:0]  hold_addr;
  logic        hold_err;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      hold_pend = 0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_instr", out_instr, hold_instr);
        check("hold_addr", {24'b0, out_addr}, {24'b0, hold_addr});
        check("hold_err", {31'b0, out_err}, {31'b0, hold_err});
      end
      hold_pend  = out_valid && !out_ready;
      hold_instr = out_instr;
      hold_addr  = out_addr;
      hold_err   = out_err;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: actual=%h required=none", out_instr);
        end else begin
          exp_t x;
          x = q.pop_front();
          check("instr", out_instr, x.instr);
          check("err", {31'b0, out_err}, {31'b0, x.err});
          check("addr", {24'b0, out_addr}, exp_addr % 256);
          check("err_cnt", {24'b0, err_cnt}, exp_errcnt);
          exp_addr = (exp_addr + 4) % 256;
          if (x.err && exp_errcnt < 255) exp_errcnt++;
        end
      end
      if (in_valid && in_ready) begin
        exp_t x;
        if (dir_use) begin
          x.instr = dir_instr;
          x.err   = dir_err;
        end else begin
          ref_encode(opcode, rd, rs1, rs2, funct3, funct7, imm, x.instr, x.err);
        end
        q.push_back(x);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] im);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  // Presents a bundle and holds it until accepted (bounded).
  task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] im);
    bit acc;
    acc = 0;
    set_fields(op, d, s1, s2, f3, f7, im);
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !acc; t++) begin
      #1;
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    dir_use  = 0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: actual=not_accepted required=accepted");
    end
  endtask

  task automatic send_dir(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im,
                          input logic [31:0] ei, input bit ee);
    dir_use = 1; dir_instr = ei; dir_err = ee;
    send(op, d, s1, s2, f3, 7'd0, im);
  endtask

  task automatic drain();
    ready_mode = 0;
    for (int t = 0; t < 40 && (q.size() != 0 || out_valid); t++) tick();
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: actual=%0d pending required=0", q.size());
    end
  endtask

  function automatic logic [31:0] rand_imm();
    int b[17] = '{-2048, 2047, -2049, 2048, -4096, 4094, 4095, -4098, 4096,
                  -1048576, 1048574, 1048576, 0, 31, 32, -1, 3};
    case ($urandom_range(0, 4))
      0: return $urandom();
      1: return 32'($signed($urandom_range(0, 8191)) - 4096);
      2: return 32'(b[$urandom_range(0, 16)]);
      3: return $urandom() & 32'hFFFF_F000;
      default: return 32'($signed($urandom_range(0, 63)) - 16);
    endcase
  endfunction

  function automatic logic [6:0] rand_op();
    logic [6:0] ops[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011};
    if ($urandom_range(0, 9) == 0) return 7'($urandom());
    return ops[$urandom_range(0, 9)];
  endfunction

  task automatic send_rand();
    send(rand_op(), 5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()),
         7'($urandom()), rand_imm());
  endtask

  initial begin
    int acc;
    ready_mode = 0;
    repeat (3) tick();
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", {24'b0, out_addr}, 32'd0);
    check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    tick();

    send_dir(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 0);
    send_dir(7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 32'd12,        32'h0051_2623, 0);
    send_dir(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFF8, 32'hFE20_8CE3, 0);
    send_dir(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048,      32'h0010_00EF, 0);
    send_dir(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3,         32'h0000_0013, 1);
    drain();
    #2 check("err_cnt_after_jal", {24'b0, err_cnt}, 32'd1);

    // Stall: out_ready low for 3 cycles; only two bundles fit.
    tick();
    ready_mode = 2;
    tick();
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_fields(7'b0010011, 5'(acc + 3), 5'd4, 5'd0, 3'd0, 7'd0, 32'(acc * 100));
      #1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("stall_accepts", 32'(acc), 32'd2);
    ready_mode = 0;
    for (int k = acc; k < 4; k++) send(7'b0010011, 5'(k + 3), 5'd4, 5'd0, 3'd0, 7'd0, 32'(k * 100));
    drain();

    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send_rand();
      if ($urandom_range(0, 4) == 0) tick();
    end
    drain();

    for (int i = 0; i < 260; i++) send(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    drain();
    #2 check("err_cnt_sat", {24'b0, err_cnt}, 32'd255);

    // Reset with both stages full.
    tick();
    ready_mode = 2;
    tick();
    send(7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    send(7'b0110011, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    exp_addr = 0;
    exp_errcnt = 0;
    #2;
    check("rst2_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst2_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst2_out_addr", {24'b0, out_addr}, 32'd0);
    check("rst2_err_cnt", {24'b0, err_cnt}, 32'd0);
    ready_mode = 1;
    tick();
    for (int i = 0; i < 40; i++) send_rand();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
